// File: rtl/eth_mac_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one MAC TX FIFO from S_COUNT AXI-stream ports.
// Oversize frames are cut at MAX_FRAME_BEATS, marked bad, and the remainder is drained from the source.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no owner; pick next requester round-robin from ptr_q+1
// ST_XFER   | forwarding beats of the granted port through the output slice
// ST_DROP   | frame truncated; swallowing granted port beats until its tlast
module eth_mac_tx_frame_arbiter #(
    parameter int S_COUNT         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_FRAME_BEATS = 1518
) (
    input  logic                          logic_clk,
    input  logic                          logic_rst,

    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT-1:0]            s_axis_tuser,

    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,

    input  logic [S_COUNT-1:0]            cfg_port_enable,
    output logic [S_COUNT-1:0]            status_grant,
    output logic [S_COUNT-1:0]            status_good_frame,
    output logic [S_COUNT-1:0]            status_bad_frame
);

    localparam int PTR_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int CNT_W = $clog2(MAX_FRAME_BEATS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_BEATS);

    logic [1:0]         state_q;
    logic [S_COUNT-1:0] grant_q;
    logic [PTR_W-1:0]   gidx_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;

    logic [DATA_WIDTH-1:0] port_data [S_COUNT];
    logic [KEEP_WIDTH-1:0] port_keep [S_COUNT];

    for (genvar i = 0; i < S_COUNT; i++) begin : g_port
        assign port_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign port_keep[i] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
    end

    logic [S_COUNT-1:0] req;
    logic               arb_found;
    logic [PTR_W-1:0]   arb_idx;
    int                 cand;

    // First requester strictly after the last completed owner, wrapping around.
    always_comb begin
        req       = s_axis_tvalid & cfg_port_enable;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int off = 1; off <= S_COUNT; off++) begin
            cand = (int'(ptr_q) + off) % S_COUNT;
            if (!arb_found && req[PTR_W'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = PTR_W'(cand);
            end
        end
    end

    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_user;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  out_ready;
    logic                  port_ready;
    logic                  accept;
    logic [CNT_W-1:0]      beat_next;
    logic                  hit_max;

    assign sel_valid = s_axis_tvalid[gidx_q];
    assign sel_last  = s_axis_tlast[gidx_q];
    assign sel_user  = s_axis_tuser[gidx_q];
    assign sel_data  = port_data[gidx_q];
    assign sel_keep  = port_keep[gidx_q];

    assign out_ready  = !m_axis_tvalid || m_axis_tready;
    // DROP never writes the output slice, so it can accept regardless of backpressure.
    assign port_ready = ((state_q == ST_XFER) && out_ready) || (state_q == ST_DROP);
    assign accept     = sel_valid && port_ready;

    assign s_axis_tready = grant_q & {S_COUNT{port_ready}};
    assign status_grant  = grant_q;

    assign beat_next = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + 1'b1;
    assign hit_max   = (beat_next == CNT_MAX);

    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            state_q           <= ST_IDLE;
            grant_q           <= '0;
            gidx_q            <= '0;
            ptr_q             <= PTR_W'(S_COUNT - 1);
            beat_cnt_q        <= '0;
            m_axis_tdata      <= '0;
            m_axis_tkeep      <= '0;
            m_axis_tvalid     <= 1'b0;
            m_axis_tlast      <= 1'b0;
            m_axis_tuser      <= 1'b0;
            status_good_frame <= '0;
            status_bad_frame  <= '0;
        end else begin
            status_good_frame <= '0;
            status_bad_frame  <= '0;

            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (arb_found) begin
                        gidx_q          <= arb_idx;
                        grant_q         <= '0;
                        grant_q[arb_idx] <= 1'b1;
                        beat_cnt_q      <= '0;
                        state_q         <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (accept) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= sel_data;
                        m_axis_tkeep  <= sel_keep;
                        beat_cnt_q    <= beat_next;
                        if (sel_last) begin
                            m_axis_tlast              <= 1'b1;
                            m_axis_tuser              <= sel_user;
                            status_good_frame[gidx_q] <= !sel_user;
                            status_bad_frame[gidx_q]  <= sel_user;
                            ptr_q                     <= gidx_q;
                            grant_q                   <= '0;
                            beat_cnt_q                <= '0;
                            state_q                   <= ST_IDLE;
                        end else if (hit_max) begin
                            m_axis_tlast             <= 1'b1;
                            m_axis_tuser             <= 1'b1;
                            status_bad_frame[gidx_q] <= 1'b1;
                            state_q                  <= ST_DROP;
                        end else begin
                            m_axis_tlast <= 1'b0;
                            m_axis_tuser <= 1'b0;
                        end
                    end
                end

                ST_DROP: begin
                    if (accept) begin
                        beat_cnt_q <= beat_next;
                        if (sel_last) begin
                            ptr_q      <= gidx_q;
                            grant_q    <= '0;
                            beat_cnt_q <= '0;
                            state_q    <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
